// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file writeback controller.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam int NUM_SRC  = 2;

  // Writeback source; value doubles as the request/grant bit index.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // One-hot register mask, all-zero when en is low.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r,
                                                     input logic              en);
    reg_onehot = en ? (NUM_REGS'(1) << r) : '0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a 1-bit priority pointer.
// ptr = 0 favours req[0] (ALU), ptr = 1 favours req[1] (LSU).
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  // Grant the favoured requester on conflict; pointer moves to the loser side.
  always_comb begin
    gnt[WB_ALU] = req[WB_ALU] & (~req[WB_LSU] | ~ptr_q);
    gnt[WB_LSU] = req[WB_LSU] & (~req[WB_ALU] |  ptr_q);
    ptr_d = ptr_q;
    if (gnt[WB_ALU])      ptr_d = 1'b1;
    else if (gnt[WB_LSU]) ptr_d = 1'b0;
  end

  // Priority pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: arbitrates ALU/LSU writebacks onto a
// single registered write port and keeps a pending-write scoreboard for
// read-after-write stall detection.
// Optional: define REGFILE_WB_CONFLICT_CNT_EN to add conflict_cnt, a
// saturating count of cycles where both requesters are valid.
module regfile_wb_ctrl
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              we3,
  output logic [REG_AW-1:0] a3,
  output logic [XLEN-1:0]   wd3,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] a1,
  input  logic [REG_AW-1:0] a2,
  output logic              stall
`ifdef REGFILE_WB_CONFLICT_CNT_EN
  ,
  output logic [XLEN-1:0]   conflict_cnt
`endif
);

  wb_req_t [NUM_SRC-1:0] req_s;
  logic    [NUM_SRC-1:0] req_v;
  logic    [NUM_SRC-1:0] gnt;
  wb_req_t               sel;
  logic                  acc;

  logic                  we3_q, we3_d;
  logic [REG_AW-1:0]     a3_q, a3_d;
  logic [XLEN-1:0]       wd3_q, wd3_d;
  logic [NUM_REGS-1:0]   pend_q, pend_d;

  // Gather both requesters into an indexed array.
  always_comb begin
    req_v[WB_ALU]      = alu_valid;
    req_v[WB_LSU]      = lsu_valid;
    req_s[WB_ALU].rd   = alu_rd;
    req_s[WB_ALU].data = alu_data;
    req_s[WB_LSU].rd   = lsu_rd;
    req_s[WB_LSU].data = lsu_data;
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_v),
    .gnt   (gnt)
  );

  // Ready is the grant itself; forced low while reset is held.
  always_comb begin
    alu_ready = rst_n & gnt[WB_ALU];
    lsu_ready = rst_n & gnt[WB_LSU];
    acc       = |gnt;
    sel       = gnt[WB_LSU] ? req_s[WB_LSU] : req_s[WB_ALU];
  end

  // Next write-port values: x0 writes are captured but never enabled.
  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (acc) begin
      we3_d = (sel.rd != '0);
      a3_d  = sel.rd;
      wd3_d = sel.data;
    end
  end

  // Scoreboard next state: clear on accepted write, then set on issue so
  // a same-cycle set wins; x0 is never pending.
  always_comb begin
    pend_d    = (pend_q & ~reg_onehot(sel.rd, acc)) | reg_onehot(iss_rd, iss_valid);
    pend_d[0] = 1'b0;
  end

  // Write-port pipeline register and scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q  <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
      pend_q <= '0;
    end else begin
      we3_q  <= we3_d;
      a3_q   <= a3_d;
      wd3_q  <= wd3_d;
      pend_q <= pend_d;
    end
  end

  assign we3 = we3_q;
  assign a3  = a3_q;
  assign wd3 = wd3_q;

  // RAW hazard on either source; no forwarding of the write in flight.
  always_comb begin
    stall = rst_n & (((a1 != '0) & pend_q[a1]) | ((a2 != '0) & pend_q[a2]));
  end

`ifdef REGFILE_WB_CONFLICT_CNT_EN
  logic [XLEN-1:0] cnt_q, cnt_d;

  // Saturating count of cycles with both requesters valid.
  always_comb begin
    cnt_d = cnt_q;
    if (alu_valid && lsu_valid && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Conflict counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule
